// File: rtl/boot_loader_if.sv
// boot_loader_if: stream-in, instruction-memory-out and status signals of the program loader.
// master = loader side, slave = stream source / memory / CPU side.
`default_nettype none

interface boot_loader_if;
  logic        start;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic [31:0] boot_addr;
  logic [31:0] boot_data;
  logic        boot_we;
  logic        cpu_debug;
  logic        done;
  logic        error;
  logic [15:0] words_loaded;

  modport master (
    input  start, rx_data, rx_valid,
    output rx_ready, boot_addr, boot_data, boot_we,
    output cpu_debug, done, error, words_loaded
  );

  modport slave (
    output start, rx_data, rx_valid,
    input  rx_ready, boot_addr, boot_data, boot_we,
    input  cpu_debug, done, error, words_loaded
  );
endinterface

`default_nettype wire

// File: rtl/boot_loader.sv
// ============================================================================
// Module   : boot_loader
// Purpose  : Framed byte-stream loader (length, LE words, optional XOR checksum)
//            writing instruction memory and holding the CPU until load succeeds.
//            Optional macro BOOT_LOADER_CSUM_EN enables the trailing checksum byte.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module boot_loader #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          MAX_WORDS = 4096
) (
  input  wire logic     clk,
  input  wire logic     rst,
  boot_loader_if.master bus
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LEN   = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_DONE  = 3'd4;
  localparam logic [2:0] S_ERROR = 3'd5;
`ifdef BOOT_LOADER_CSUM_EN
  localparam logic [2:0] S_CSUM  = 3'd3;
  localparam logic [2:0] S_POST  = S_CSUM;
`else
  localparam logic [2:0] S_POST  = S_DONE;
`endif
  localparam logic [31:0] C_MAX_LEN = 32'(MAX_WORDS);

  logic [2:0]  r_state;
  logic [2:0]  w_next_state;

  logic        r_rx_ready;
  logic [31:0] r_boot_addr;
  logic [31:0] r_boot_data;
  logic        r_boot_we;
  logic        r_cpu_debug;
  logic        r_done;
  logic        r_error;
  logic [15:0] r_words_loaded;

  logic [1:0]  r_byte_idx;
  logic [31:0] r_len;
  logic [23:0] r_asm;
  logic        r_final;
`ifdef BOOT_LOADER_CSUM_EN
  logic [7:0]  r_csum;
`endif

  logic        w_acc;
  logic        w_start;
  logic        w_byte4;
  logic        w_last;
  logic        w_final_set;
  logic [31:0] w_len_full;
  logic [31:0] w_word;

  logic        w_rx_ready_nxt;
  logic        w_cpu_debug_nxt;
  logic        w_done_nxt;
  logic        w_error_nxt;

  assign w_acc      = bus.rx_valid && r_rx_ready;
  assign w_start    = bus.start && ((r_state == S_IDLE) || (r_state == S_DONE) ||
                                    (r_state == S_ERROR));
  assign w_byte4    = w_acc && (r_byte_idx == 2'd3);
  assign w_len_full = {bus.rx_data, r_len[31:8]};
  assign w_word     = {bus.rx_data, r_asm};
  assign w_last     = (({16'h0000, r_words_loaded} + 32'd1) == r_len);
  assign w_final_set = (r_state == S_DATA) && w_byte4 && w_last;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE, S_DONE, S_ERROR: begin
        if (bus.start) w_next_state = S_LEN;
      end
      S_LEN: begin
        if (w_byte4) begin
          if (w_len_full > C_MAX_LEN)      w_next_state = S_ERROR;
          else if (w_len_full == 32'd0)    w_next_state = S_POST;
          else                             w_next_state = S_DATA;
        end
      end
      S_DATA: begin
        // Leave only once the final word's strobe is on the bus.
        if (r_boot_we && r_final) w_next_state = S_POST;
      end
`ifdef BOOT_LOADER_CSUM_EN
      S_CSUM: begin
        if (w_acc) w_next_state = (bus.rx_data == r_csum) ? S_DONE : S_ERROR;
      end
`endif
      default: w_next_state = S_IDLE;
    endcase
  end

  // Output decode from the next state, so the flops below align with r_state.
  always_comb begin
    w_rx_ready_nxt  = 1'b0;
    w_cpu_debug_nxt = 1'b1;
    w_done_nxt      = 1'b0;
    w_error_nxt     = 1'b0;
    case (w_next_state)
      S_LEN:   w_rx_ready_nxt = 1'b1;
      // No byte is taken past the last word while its strobe is pending.
      S_DATA:  w_rx_ready_nxt = !(w_final_set || r_final);
`ifdef BOOT_LOADER_CSUM_EN
      S_CSUM:  w_rx_ready_nxt = 1'b1;
`endif
      S_DONE: begin
        w_done_nxt      = 1'b1;
        w_cpu_debug_nxt = 1'b0;
      end
      S_ERROR: w_error_nxt = 1'b1;
      default: w_rx_ready_nxt = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rx_ready  <= 1'b0;
      r_cpu_debug <= 1'b1;
      r_done      <= 1'b0;
      r_error     <= 1'b0;
    end else begin
      r_rx_ready  <= w_rx_ready_nxt;
      r_cpu_debug <= w_cpu_debug_nxt;
      r_done      <= w_done_nxt;
      r_error     <= w_error_nxt;
    end
  end

  // Datapath: length/word assembly, checksum, write strobe and address stepping
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_boot_addr    <= BASE_ADDR;
      r_boot_data    <= 32'h0;
      r_boot_we      <= 1'b0;
      r_words_loaded <= 16'h0;
      r_byte_idx     <= 2'd0;
      r_len          <= 32'h0;
      r_asm          <= 24'h0;
      r_final        <= 1'b0;
`ifdef BOOT_LOADER_CSUM_EN
      r_csum         <= 8'h0;
`endif
    end else begin
      r_boot_we <= 1'b0;
      if (w_start) begin
        r_boot_addr    <= BASE_ADDR;
        r_words_loaded <= 16'h0;
        r_byte_idx     <= 2'd0;
        r_len          <= 32'h0;
        r_final        <= 1'b0;
`ifdef BOOT_LOADER_CSUM_EN
        r_csum         <= 8'h0;
`endif
      end else if (r_state == S_LEN) begin
        if (w_acc) begin
          r_len      <= w_len_full;
          r_byte_idx <= r_byte_idx + 2'd1;
        end
      end else if (r_state == S_DATA) begin
        if (w_acc) begin
          r_asm      <= w_word[31:8];
          r_byte_idx <= r_byte_idx + 2'd1;
`ifdef BOOT_LOADER_CSUM_EN
          r_csum     <= r_csum ^ bus.rx_data;
`endif
          if (r_byte_idx == 2'd3) begin
            r_boot_we   <= 1'b1;
            r_boot_data <= w_word;
          end
        end
        if (w_final_set) r_final <= 1'b1;
        if (r_boot_we) begin
          r_boot_addr    <= r_boot_addr + 32'd4;
          r_words_loaded <= r_words_loaded + 16'd1;
        end
      end
    end
  end

  assign bus.rx_ready     = r_rx_ready;
  assign bus.boot_addr    = r_boot_addr;
  assign bus.boot_data    = r_boot_data;
  assign bus.boot_we      = r_boot_we;
  assign bus.cpu_debug    = r_cpu_debug;
  assign bus.done         = r_done;
  assign bus.error        = r_error;
  assign bus.words_loaded = r_words_loaded;

endmodule

`default_nettype wire

// File: doc/boot_loader.md
Name: boot_loader

Overview:
- Byte-stream program loader that sits directly upstream of the cpu boot interface.
- Accepts a framed byte stream: a length, program words, then an optional checksum.
- Assembles little-endian 32-bit words and drives boot_addr/boot_data/boot_we into instruction memory.
- Holds the CPU in debug (stalled) until the load completes successfully, then releases it.

Parameters:
- BASE_ADDR, 32'h0000_0000, byte address of the first program word.
- MAX_WORDS, 4096, largest legal word count; a larger length is an error.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous active-high reset
- start  input  1  one-cycle pulse; begins a new load from IDLE, DONE or ERROR
- rx_data  input  8  incoming stream byte
- rx_valid  input  1  rx_data is valid
- rx_ready  output  1  loader accepts a byte this cycle; a byte transfers when rx_valid && rx_ready
- boot_addr  output  32  instruction-memory byte address
- boot_data  output  32  instruction word
- boot_we  output  1  one-cycle write strobe
- cpu_debug  output  1  high = CPU held; connects to the cpu debug input
- done  output  1  load complete, level
- error  output  1  load failed, level
- words_loaded  output  16  count of words written so far

Behaviour:
- Reset (async, rst=1) values:
  - state=IDLE; rx_ready=0; boot_addr=BASE_ADDR; boot_data=0; boot_we=0.
  - cpu_debug=1; done=0; error=0; words_loaded=0.
  - Internal byte index, length and checksum registers cleared.
- States: IDLE, LEN, DATA, CSUM, DONE, ERROR.
- IDLE:
  - rx_ready=0; cpu_debug=1.
  - On start go to LEN: clear byte index, checksum, words_loaded and done/error; set boot_addr=BASE_ADDR.
- LEN:
  - rx_ready=1; accept 4 bytes forming length N, little-endian (first byte = N[7:0]).
  - After the 4th byte:
    - N > MAX_WORDS -> ERROR.
    - N == 0 -> CSUM, or DONE if the macro is absent.
    - Otherwise -> DATA.
- DATA:
  - rx_ready=1; accept bytes, shifting them into the word little-endian.
  - Every data byte is XORed into the 8-bit checksum.
  - Cycle after the 4th byte of a word is accepted: boot_we=1 for exactly one cycle, with boot_data=assembled word and boot_addr=the current word address.
  - The cycle after the strobe: boot_addr += 4 and words_loaded += 1.
  - A byte may be accepted in the same cycle as the strobe; the assembly register is separate from boot_data.
  - When words_loaded reaches N (after the final strobe): -> CSUM, or DONE if the macro is absent.
- CSUM (only when the macro is defined):
  - rx_ready=1; accept one byte.
  - Equal to the running XOR -> DONE; otherwise -> ERROR.
- DONE: rx_ready=0; done=1; cpu_debug=0.
- ERROR: rx_ready=0; error=1; cpu_debug=1.
- start in DONE or ERROR: same as from IDLE; cpu_debug returns to 1 on the next cycle.
- start in LEN, DATA or CSUM: ignored.
- rx_valid=0 stalls the machine in its state with no side effects; partial words are retained indefinitely.
- Address arithmetic: 32-bit, wraps modulo 2^32. words_loaded is 16-bit.
- Reset mid-load: immediate return to reset values; no further boot_we; the partial word is discarded.
- Registered outputs only; no combinational path from rx_valid to rx_ready.

Optional Feature:
- Macro BOOT_LOADER_CSUM_EN.
- Defined: the CSUM state exists and a trailing XOR checksum byte is required and checked; a mismatch asserts error.
- Undefined: the CSUM state is removed; DONE follows the last word strobe, or the length field when N=0; no checksum byte is consumed.

Test Plan:
- Basic load: start, then bytes 02 00 00 00 | 13 05 10 00 | 73 00 00 00 | (macro on) checksum 0x75 ->
  - boot_we pulses twice: addr 0x0 data 0x00100513, then addr 0x4 data 0x00000073.
  - done=1, cpu_debug=0, words_loaded=2.
- Bad checksum (macro on): same stream with checksum 0x00 -> both writes occur, error=1, done=0, cpu_debug stays 1.
- Length overflow: MAX_WORDS=4, length bytes 05 00 00 00 -> ERROR immediately after the 4th byte, no boot_we, rx_ready=0.
- Zero length and backpressure:
  - Length 00 00 00 00 -> DONE (macro off) or awaits checksum 0x00 (macro on); no writes.
  - Separately, rx_valid toggled every other cycle during DATA -> identical writes, just delayed.
- Mid-load reset: assert rst after 6 bytes of a 2-word load ->
  - All outputs return to reset values within the same cycle; no boot_we.
  - A fresh start plus the full stream then loads correctly from BASE_ADDR.
- Restart from DONE: start after a successful load -> cpu_debug=1 the next cycle, done=0, a new load begins at BASE_ADDR with words_loaded=0.
